sha256_stream_core: RTL and testbench
=====================================

Name: sha256_stream_core

Overview:
- Parametrised successor to the fixed-size SHA-256 engine.
- Hashes a message of NUM_OF_WORDS 32-bit words read from the shared single-port testbench/system memory, then writes the digest back to that memory.
- Generates standard SHA-256 padding on the fly for any message length, and processes any number of 512-bit blocks.
- Keeps only a rolling 16-word W window, so it never buffers the whole message.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words (1..65535).
- MEM_ADDR_W, 16, memory address width.
- DIGEST_WORDS, 8, digest words written back (8 for SHA-256; forced to 7 under SHA224_MODE_EN).

Ports:
- clk  in  1  system clock; also drives mem_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- message_addr  in  MEM_ADDR_W  first message word address, latched on start.
- output_addr  in  MEM_ADDR_W  first digest word address, latched on start.
- done  out  1  high while IDLE.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_ADDR_W  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data, valid one cycle after its address.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values: state IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0.
- Reset asserted mid-operation aborts immediately; there is no partial write-back after reset.
- Block count: NUM_BLOCKS = (NUM_OF_WORDS+2)/16 + 1, integer division, computed as a localparam.
  - Examples: N=13 gives 1 block; N=14 gives 2; N=20 gives 2; N=30 gives 3.
- Word source for global index g = blk*16 + j:
  - g < N: memory word at message_addr+g.
  - g == N: 32'h80000000.
  - Last block, j=14: upper 32 bits of 64-bit bit-length N*32.
  - Last block, j=15: lower 32 bits of N*32.
  - Otherwise: 0.
- Address arithmetic wraps modulo 2^MEM_ADDR_W.
- FSM states: IDLE, READ, COMPUTE, UPDATE, WRITE.
- IDLE:
  - On start=1: latch both addresses, load H0..H7 and a..h with the IVs, set blk=0, go to READ.
  - start is ignored in every other state.
- READ, 17 cycles:
  - Cycles 0..15 issue address message_addr+blk*16+j.
  - Cycles 1..16 capture word j-1 into W[j-1], substituting the padding/length word where required.
  - mem_we stays 0. Padding-only words still occupy a cycle, so timing is fixed.
- COMPUTE, 64 cycles, one round per cycle, t=0..63:
  - Rounds t<16 use W[t].
  - Rounds t>=16 use the expanded word: W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]).
  - The 16-entry W window shifts by one each round.
  - K[t] is indexed by the round counter.
- UPDATE, 1 cycle:
  - Hi <= Hi + {a..h}[i], then a..h <= new Hi.
  - blk++; go to READ if blk < NUM_BLOCKS-1, else to WRITE.
- WRITE, DIGEST_WORDS cycles:
  - mem_we=1, mem_addr=output_addr+k, mem_write_data=Hk for k=0..DIGEST_WORDS-1.
  - Then mem_we=0 and go to IDLE.
- All arithmetic is mod 2^32; rotates are true 32-bit rotates.
- Latency: done falls the cycle after start is sampled and rises exactly 82*NUM_BLOCKS + DIGEST_WORDS + 1 cycles after the sampling edge.
  - For N=20: 173 cycles.
- A start asserted in the same cycle done rises is accepted, giving back-to-back hashing with no idle gap.

Optional Feature:
- Macro: SHA224_MODE_EN.
- Defined:
  - IVs are the SHA-224 constants (c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4).
  - Only H0..H6 are written back (7 write cycles), so latency is 82*NUM_BLOCKS+8.
- Undefined: SHA-256 IVs and 8 digest words.
- The round function and padding are identical in both modes.

Decomposition:
- Package sha256_pkg holds:
  - State enum.
  - K[0:63] constant array.
  - SHA-256 and SHA-224 IV arrays.
  - Functions: rightrotate, sigma0/sigma1, Sigma0/Sigma1, ch, maj, num_blocks(N).
- One sub-module, sha256_round: purely combinational, taking a..h, K[t] and Wt and returning the next a..h.
  - It is instantiated once; the FSM, W window and memory sequencing stay in sha256_stream_core.

Test Plan:
- N=1, mem[0x0000]=32'h61626364 ("abcd"), output_addr=0x0100 -> mem[0x100..0x107] = 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589; done high 91 cycles after start.
- N=20, random words at message_addr=0x0000, output_addr=0x0200 -> digest equals the software reference model; exactly 8 writes; no reads outside 0x0000..0x0013.
- Block-boundary sweep: N=13, 14, 16, 30 -> NUM_BLOCKS 1/2/2/3; digests match the model; latencies 91/173/173/255 cycles.
- Reset asserted during COMPUTE of block 0 with N=20 -> done=1 and mem_we=0 immediately with no write; a fresh start then produces the correct digest.
- start held high through the whole operation, with message_addr changed mid-hash -> the second hash starts only when done rises, and the first digest uses the originally latched address.
- SHA224_MODE_EN build, N=1 "abcd" -> 7 words match the SHA-224 reference; output_addr+7 is not written.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, round constants, IV tables and SHA-256 helper functions for sha256_stream_core.
// Row 1 of IV_TABLE holds the SHA-224 IVs, selected when SHA224_MODE_EN is defined.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        WRITE   = 3'd4
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_TABLE [2][8] = '{
        '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19},
        '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4}
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Message words plus the 0x80000000 marker and the two length words, rounded up to 16.
    function automatic int num_blocks(input int n);
        return (n + 2) / 16 + 1;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working variables a..h (index 0 = a) in, next a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] v_in  [8],
    input  logic [31:0] k_t,
    input  logic [31:0] w_t,
    output logic [31:0] v_out [8]
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = v_in[7] + Sigma1(v_in[4]) + ch(v_in[4], v_in[5], v_in[6]) + k_t + w_t;
        t2 = Sigma0(v_in[0]) + maj(v_in[0], v_in[1], v_in[2]);
        v_out[0] = t1 + t2;
        v_out[1] = v_in[0];
        v_out[2] = v_in[1];
        v_out[3] = v_in[2];
        v_out[4] = v_in[3] + t1;
        v_out[5] = v_in[4];
        v_out[6] = v_in[5];
        v_out[7] = v_in[6];
    end

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 over NUM_OF_WORDS memory words with on-the-fly padding and a rolling 16-word W window.
// Defining SHA224_MODE_EN switches to SHA-224 IVs and a 7-word digest write-back.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20,
    parameter int MEM_ADDR_W   = 16,
    parameter int DIGEST_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] message_addr,
    input  logic [MEM_ADDR_W-1:0] output_addr,
    output logic                  done,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    localparam int NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
`ifdef SHA224_MODE_EN
    localparam int DW     = 7;
    localparam int IV_SEL = 1;
`else
    localparam int DW     = DIGEST_WORDS;
    localparam int IV_SEL = 0;
`endif
    localparam logic [63:0] BIT_LEN = 64'(NUM_OF_WORDS) * 64'd32;
    localparam logic [31:0] N_WORDS = 32'(NUM_OF_WORDS);

    state_t                state, state_nxt;
    logic [6:0]            cnt;
    logic [15:0]           blk;
    logic [MEM_ADDR_W-1:0] msg_base, out_base;
    logic [31:0]           h_reg [8];
    logic [31:0]           v_reg [8];
    logic [31:0]           v_nxt [8];
    logic [31:0]           w     [16];
    logic                  last_blk;
    logic [31:0]           g_cap, g_next_rd, g_next_blk, cap_word, w_new, k_t;
    logic [3:0]            j_cap;

    assign mem_clk  = clk;
    assign done     = (state == IDLE);
    assign last_blk = (blk == 16'(NUM_BLOCKS - 1));
    assign k_t      = K[cnt[5:0]];

    // Capture in READ cycle cnt lands word cnt-1 of the block; cnt=16 wraps j_cap to 15.
    always_comb begin
        g_cap      = {12'b0, blk, 4'b0} + {25'b0, cnt} - 32'd1;
        g_next_rd  = {12'b0, blk, 4'b0} + {25'b0, cnt} + 32'd1;
        g_next_blk = {12'b0, blk, 4'b0} + 32'd16;
        j_cap      = cnt[3:0] - 4'd1;
        w_new      = w[0] + sigma0(w[1]) + w[9] + sigma1(w[14]);
        cap_word   = 32'h0;
        if (g_cap < N_WORDS)                 cap_word = mem_read_data;
        else if (g_cap == N_WORDS)           cap_word = 32'h80000000;
        else if (last_blk && j_cap == 4'd14) cap_word = BIT_LEN[63:32];
        else if (last_blk && j_cap == 4'd15) cap_word = BIT_LEN[31:0];
    end

    sha256_round u_round (
        .v_in  (v_reg),
        .k_t   (k_t),
        .w_t   (w[0]),
        .v_out (v_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (cnt == 7'd16) state_nxt = COMPUTE;
            COMPUTE: if (cnt == 7'd63) state_nxt = UPDATE;
            UPDATE:  state_nxt = last_blk ? WRITE : READ;
            WRITE:   if (cnt == 7'(DW)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            blk            <= '0;
            msg_base       <= '0;
            out_base       <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= '0;
                v_reg[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    msg_base <= message_addr;
                    out_base <= output_addr;
                    mem_addr <= message_addr;
                    blk      <= '0;
                    cnt      <= '0;
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= IV_TABLE[IV_SEL][i];
                        v_reg[i] <= IV_TABLE[IV_SEL][i];
                    end
                end
                // Padding-only slots keep the last message address on the bus.
                READ: begin
                    if (cnt != 7'd0) w[j_cap] <= cap_word;
                    if (cnt < 7'd15 && g_next_rd < N_WORDS)
                        mem_addr <= msg_base + MEM_ADDR_W'(g_next_rd);
                    cnt <= (cnt == 7'd16) ? 7'd0 : cnt + 7'd1;
                end
                COMPUTE: begin
                    for (int i = 0; i < 8; i++) v_reg[i] <= v_nxt[i];
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    cnt   <= (cnt == 7'd63) ? 7'd0 : cnt + 7'd1;
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= h_reg[i] + v_reg[i];
                        v_reg[i] <= h_reg[i] + v_reg[i];
                    end
                    blk <= blk + 16'd1;
                    cnt <= '0;
                    if (!last_blk && g_next_blk < N_WORDS)
                        mem_addr <= msg_base + MEM_ADDR_W'(g_next_blk);
                end
                WRITE: begin
                    if (cnt < 7'(DW)) begin
                        mem_we         <= 1'b1;
                        mem_addr       <= out_base + MEM_ADDR_W'(cnt);
                        mem_write_data <= h_reg[cnt[2:0]];
                        cnt            <= cnt + 7'd1;
                    end else begin
                        mem_we <= 1'b0;
                        cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: one instance per message length, each with its own memory and write log,
// checked against a software SHA-256/224 model.
module tb_sha256_stream_core;

    localparam int NI = 6;
    localparam int NS [NI] = '{1, 13, 14, 16, 20, 30};
`ifdef SHA224_MODE_EN
    localparam int DW = 7;
    localparam logic [31:0] TB_IV [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`else
    localparam int DW = 8;
    localparam logic [31:0] TB_IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] ABCD_DIGEST [8] = '{32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
                                                32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589};
`endif
    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic           clk = 1'b0;
    logic           reset;
    logic [NI-1:0]  start_v, done_v, memclk_v, we_v;
    logic [15:0]    maddr_v [NI];
    logic [15:0]    oaddr_v [NI];
    logic [15:0]    mem_addr_v [NI];
    logic [31:0]    wdata_v [NI];
    logic [31:0]    rdata_v [NI];
    logic [31:0]    msg_mem [NI][256];
    logic [15:0]    wlog_addr [NI][256];
    logic [31:0]    wlog_data [NI][256];
    int             wr_cnt [NI];
    int             checks;
    int             failures;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sha256_stream_core #(
            .NUM_OF_WORDS (NS[gi]),
            .MEM_ADDR_W   (16),
            .DIGEST_WORDS (8)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start_v[gi]),
            .message_addr   (maddr_v[gi]),
            .output_addr    (oaddr_v[gi]),
            .done           (done_v[gi]),
            .mem_clk        (memclk_v[gi]),
            .mem_we         (we_v[gi]),
            .mem_addr       (mem_addr_v[gi]),
            .mem_write_data (wdata_v[gi]),
            .mem_read_data  (rdata_v[gi])
        );
    end

    // Registered read port per instance; every write is appended to that instance's log.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rdata_v[i] <= msg_mem[i][mem_addr_v[i][7:0]];
            if (we_v[i]) begin
                wlog_addr[i][wr_cnt[i] % 256] <= mem_addr_v[i];
                wlog_data[i][wr_cnt[i] % 256] <= wdata_v[i];
                wr_cnt[i] <= wr_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic sha_ref(input logic [31:0] msg[$], output logic [31:0] dig[8], output int nb);
        logic [31:0] p[$];
        logic [31:0] w[64];
        logic [31:0] v[8];
        logic [31:0] t1, t2, s0, s1;
        logic [63:0] len;
        p = msg;
        p.push_back(32'h80000000);
        while (p.size() % 16 != 14) p.push_back(32'h0);
        len = 64'(msg.size()) * 64'd32;
        p.push_back(len[63:32]);
        p.push_back(len[31:0]);
        nb = p.size() / 16;
        for (int k = 0; k < 8; k++) dig[k] = TB_IV[k];
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = p[b*16 + t];
                else begin
                    s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                    s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                    w[t] = w[t-16] + s0 + w[t-7] + s1;
                end
            end
            v = dig;
            for (int t = 0; t < 64; t++) begin
                s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
                t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
                s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
                t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int r = 7; r > 0; r--) v[r] = v[r-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int k = 0; k < 8; k++) dig[k] = dig[k] + v[k];
        end
    endtask

    task automatic fill_msg(input int i, input logic [15:0] ma);
        logic [15:0] a;
        for (int k = 0; k < NS[i]; k++) begin
            a = ma + 16'(k);
            msg_mem[i][a[7:0]] = $urandom();
        end
    endtask

    task automatic model_digest(input int i, input logic [15:0] ma, output logic [31:0] dig[8], output int nb);
        logic [31:0] q[$];
        logic [15:0] a;
        for (int k = 0; k < NS[i]; k++) begin
            a = ma + 16'(k);
            q.push_back(msg_mem[i][a[7:0]]);
        end
        sha_ref(q, dig, nb);
    endtask

    // Entered at the falling edge just after the sampling edge; cyc counts rising edges since it.
    task automatic wait_done(input int i, input int limit, input logic [15:0] lo, input logic [15:0] hi,
                             input int rd_lim, output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        while (!done_v[i] && cyc < limit) begin
            if (cyc < rd_lim && (we_v[i] || mem_addr_v[i] < lo || mem_addr_v[i] > hi)) bad++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_writes(input int i, input int base, input logic [15:0] oa,
                                input logic [31:0] exp_d[8], output logic [31:0] obs[8]);
        check("write_count", 32'(wr_cnt[i] - base), 32'(DW));
        for (int k = 0; k < 8; k++) obs[k] = 32'h0;
        for (int k = 0; k < DW; k++) begin
            check("write_addr", 32'(wlog_addr[i][(base + k) % 256]), 32'(oa + 16'(k)));
            obs[k] = wlog_data[i][(base + k) % 256];
            check("digest_word", obs[k], exp_d[k]);
        end
    endtask

    task automatic run_hash(input int i, input logic [15:0] ma, input logic [15:0] oa, output logic [31:0] obs[8]);
        logic [31:0] exp_d[8];
        int nb, cyc, bad, base;
        model_digest(i, ma, exp_d, nb);
        base = wr_cnt[i];
        @(negedge clk);
        maddr_v[i] = ma;
        oaddr_v[i] = oa;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        wait_done(i, 2000, ma, ma + 16'(NS[i] - 1), 82 * nb, cyc, bad);
        check("latency", 32'(cyc), 32'(82 * nb + DW + 1));
        check("read_range", 32'(bad), 32'd0);
        check_writes(i, base, oa, exp_d, obs);
    endtask

    initial begin
        logic [31:0] obs[8];
        logic [31:0] dig_a[8];
        logic [31:0] dig_b[8];
        int nb, cyc, bad, base;
        logic [15:0] ma, oa;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start_v  = '0;
        for (int i = 0; i < NI; i++) begin
            maddr_v[i] = '0;
            oaddr_v[i] = '0;
            for (int k = 0; k < 256; k++) msg_mem[i][k] = 32'h0;
        end

        repeat (3) @(negedge clk);
        check("rst_done", 32'(done_v[0]), 32'd1);
        check("rst_we", 32'(we_v[0]), 32'd0);
        check("rst_addr", 32'(mem_addr_v[0]), 32'd0);
        check("rst_wdata", wdata_v[0], 32'd0);
        check("mem_clk", 32'(memclk_v[0]), 32'(clk));
        reset = 1'b0;

        // "abcd" single-word message
        msg_mem[0][0] = 32'h61626364;
        run_hash(0, 16'h0000, 16'h0100, obs);
`ifndef SHA224_MODE_EN
        for (int k = 0; k < 8; k++) check("abcd_vector", obs[k], ABCD_DIGEST[k]);
`endif

        fill_msg(4, 16'h0000);
        run_hash(4, 16'h0000, 16'h0200, obs);

        // Block-boundary sweep, then random placements on every length
        foreach (NS[i]) begin
            if (i != 0 && i != 4) begin
                fill_msg(i, 16'h0000);
                run_hash(i, 16'h0000, 16'h0100, obs);
            end
        end
        for (int i = 0; i < NI; i++) begin
            ma = 16'($urandom_range(0, 200));
            oa = 16'($urandom_range(16'h0300, 16'hfff0));
            fill_msg(i, ma);
            run_hash(i, ma, oa, obs);
        end

        // Reset during COMPUTE of block 0
        fill_msg(4, 16'h0000);
        @(negedge clk);
        maddr_v[4] = 16'h0000;
        oaddr_v[4] = 16'h0200;
        start_v[4] = 1'b1;
        @(negedge clk);
        start_v[4] = 1'b0;
        repeat (30) @(negedge clk);
        base  = wr_cnt[4];
        reset = 1'b1;
        #1;
        check("abort_done", 32'(done_v[4]), 32'd1);
        check("abort_we", 32'(we_v[4]), 32'd0);
        check("abort_addr", 32'(mem_addr_v[4]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_write", 32'(wr_cnt[4] - base), 32'd0);
        check("abort_idle", 32'(done_v[4]), 32'd1);
        run_hash(4, 16'h0000, 16'h0200, obs);

        // start held high, message_addr moved mid-hash
        fill_msg(4, 16'h0000);
        fill_msg(4, 16'h0040);
        model_digest(4, 16'h0040, dig_b, nb);
        model_digest(4, 16'h0000, dig_a, nb);
        base = wr_cnt[4];
        @(negedge clk);
        maddr_v[4] = 16'h0000;
        oaddr_v[4] = 16'h0200;
        start_v[4] = 1'b1;
        @(negedge clk);
        repeat (30) @(negedge clk);
        maddr_v[4] = 16'h0040;
        wait_done(4, 2000, 16'h0, 16'h0, 0, cyc, bad);
        check("held_first_latency", 32'(cyc + 30), 32'(82 * nb + DW + 1));
        check_writes(4, base, 16'h0200, dig_a, obs);
        base = wr_cnt[4];
        @(negedge clk);
        check("held_back_to_back", 32'(done_v[4]), 32'd0);
        start_v[4] = 1'b0;
        wait_done(4, 2000, 16'h0, 16'h0, 0, cyc, bad);
        check("held_second_latency", 32'(cyc), 32'(82 * nb + DW + 1));
        check_writes(4, base, 16'h0200, dig_b, obs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
